// File: rtl/mem_stage.sv
// MINAv2 memory stage: loads/stores over a single-master req/ack data bus, registered writeback.
// Optional misalignment fault reporting is compiled in with MEM_ALIGN_CHECK_EN.
package types;
  typedef enum logic [3:0] {
    MEM_OP_NONE,
    MEM_OP_LB,
    MEM_OP_LBU,
    MEM_OP_LH,
    MEM_OP_LHU,
    MEM_OP_LW,
    MEM_OP_SB,
    MEM_OP_SH,
    MEM_OP_SW
  } mem_op_t;

  typedef struct packed {
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    mem_op_t     mem_op;
    logic [31:0] mem_data;
  } mem_params_t;
endpackage

module mem_stage
  import types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  mem_params_t mem_params,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [3:0]  wb_rd_addr,
  output logic [31:0] wb_rd_data,
  output logic        wb_we,
  output logic        mem_fault
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic        is_load, is_store, is_mem;
  logic        size_b, size_h, size_w;
  logic [1:0]  a_raw, a_eff;
  logic        fault;
  logic        issue, fault_now;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  mem_op_t     op_q;
  logic [1:0]  a_q;
  logic [3:0]  rd_q;
  logic [31:0] sh_byte, sh_half, ld_val;

  assign a_raw = mem_params.rd_data[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_b   = 1'b0;
    size_h   = 1'b0;
    size_w   = 1'b0;
    case (mem_params.mem_op)
      MEM_OP_LB, MEM_OP_LBU: begin is_load  = 1'b1; size_b = 1'b1; end
      MEM_OP_LH, MEM_OP_LHU: begin is_load  = 1'b1; size_h = 1'b1; end
      MEM_OP_LW:             begin is_load  = 1'b1; size_w = 1'b1; end
      MEM_OP_SB:             begin is_store = 1'b1; size_b = 1'b1; end
      MEM_OP_SH:             begin is_store = 1'b1; size_h = 1'b1; end
      MEM_OP_SW:             begin is_store = 1'b1; size_w = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

  // Offsets are forced to natural alignment; with the check enabled a misaligned
  // access never reaches the bus, so forcing is a no-op there.
  always_comb begin
    a_eff = a_raw;
    if (size_w)
      a_eff = 2'b00;
    else if (size_h)
      a_eff = {a_raw[1], 1'b0};
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign fault = is_mem & ((size_h & a_raw[0]) | (size_w & (a_raw != 2'b00)));
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = mem_params.mem_data;
    if (size_b) begin
      be_d    = 4'b0001 << a_eff;
      wdata_d = {4{mem_params.mem_data[7:0]}};
    end else if (size_h) begin
      be_d    = 4'b0011 << {a_eff[1], 1'b0};
      wdata_d = {2{mem_params.mem_data[15:0]}};
    end
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    issue     = 1'b0;
    fault_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          stall = 1'b1;
          if (fault) begin
            fault_now = 1'b1;
            state_d   = ST_DONE;
          end else begin
            issue   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (dbus_ack)
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  assign sh_byte = dbus_rdata >> {a_q, 3'b000};
  assign sh_half = dbus_rdata >> {a_q[1], 4'b0000};

  always_comb begin
    ld_val = dbus_rdata;
    case (op_q)
      MEM_OP_LB:  ld_val = {{24{sh_byte[7]}}, sh_byte[7:0]};
      MEM_OP_LBU: ld_val = {24'd0, sh_byte[7:0]};
      MEM_OP_LH:  ld_val = {{16{sh_half[15]}}, sh_half[15:0]};
      MEM_OP_LHU: ld_val = {16'd0, sh_half[15:0]};
      default:    ld_val = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_be    <= 4'd0;
      dbus_wdata <= 32'd0;
      wb_rd_addr <= 4'd0;
      wb_rd_data <= 32'd0;
      wb_we      <= 1'b0;
      op_q       <= MEM_OP_NONE;
      a_q        <= 2'd0;
      rd_q       <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!is_mem) begin
            wb_rd_addr <= mem_params.rd_addr;
            wb_rd_data <= mem_params.rd_data;
            wb_we      <= (mem_params.rd_addr != 4'd0);
          end else begin
            wb_we <= 1'b0;
            if (issue) begin
              dbus_req   <= 1'b1;
              dbus_we    <= is_store;
              dbus_addr  <= {mem_params.rd_data[31:2], 2'b00};
              dbus_be    <= be_d;
              dbus_wdata <= wdata_d;
              op_q       <= mem_params.mem_op;
              a_q        <= a_eff;
              rd_q       <= mem_params.rd_addr;
            end
          end
        end
        ST_REQ: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            if (!dbus_we) begin
              wb_rd_addr <= rd_q;
              wb_rd_data <= ld_val;
              wb_we      <= (rd_q != 4'd0);
            end else begin
              wb_we <= 1'b0;
            end
          end
        end
        default: wb_we <= 1'b0;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      mem_fault <= 1'b0;
    else
      mem_fault <= fault_now;
  end
`else
  assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a byte-lane transaction model.
module tb_mem_stage;
  import types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  mem_params_t mem_params;
  logic        stall, dbus_req, dbus_we, dbus_ack, wb_we, mem_fault;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, wb_rd_data;
  logic [3:0]  dbus_be, wb_rd_addr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .mem_params(mem_params), .stall(stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .wb_we(wb_we), .mem_fault(mem_fault)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int op_size(input mem_op_t op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
      default:                          return 4;
    endcase
  endfunction

  function automatic bit op_load(input mem_op_t op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic bit op_signed(input mem_op_t op);
    return op inside {MEM_OP_LB, MEM_OP_LH};
  endfunction

  function automatic logic [3:0] model_be(input int ea, input int sz);
    logic [3:0] be = 4'd0;
    for (int i = 0; i < 4; i++)
      be[i] = (i >= ea) && (i < ea + sz);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] md, input int sz);
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = md[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input int ea, input int sz, input bit sgn);
    longint v = 0;
    for (int j = 0; j < sz; j++)
      v = v + (longint'(rd[8*(ea+j) +: 8]) << (8*j));
    if (sgn && sz < 4 && v >= (longint'(1) << (8*sz - 1)))
      v = v - (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  // Drive one op at a negedge and follow it through the stage; returns at the
  // negedge of the cycle where the next op may be presented.
  task automatic do_op(input mem_op_t op, input logic [3:0] rd, input logic [31:0] addr,
                       input logic [31:0] md, input int k, input logic [31:0] rdata);
    int sz, ea;
    bit ld, mis;
    mem_params.mem_op   = op;
    mem_params.rd_addr  = rd;
    mem_params.rd_data  = addr;
    mem_params.mem_data = md;
    dbus_ack   = (op == MEM_OP_NONE) ? 1'($urandom_range(0, 1)) : 1'b0;
    dbus_rdata = $urandom;
    #1;
    check("stall_issue", stall, op != MEM_OP_NONE);
    if (op == MEM_OP_NONE) begin
      @(negedge clk);
      dbus_ack = 1'b0;
      check("alu_wb_we", wb_we, rd != 4'd0);
      check("alu_wb_addr", wb_rd_addr, rd);
      check("alu_wb_data", wb_rd_data, addr);
      check("alu_no_req", dbus_req, 0);
      return;
    end
    sz  = op_size(op);
    ld  = op_load(op);
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`ifdef MEM_ALIGN_CHECK_EN
    if (mis) begin
      @(negedge clk);
      check("flt_pulse", mem_fault, 1);
      check("flt_no_req", dbus_req, 0);
      check("flt_stall", stall, 0);
      check("flt_wb_we", wb_we, 0);
      @(negedge clk);
      check("flt_clear", mem_fault, 0);
      check("flt_no_req2", dbus_req, 0);
      check("flt_wb_we2", wb_we, 0);
      return;
    end
`endif
    ea = int'(addr[1:0]) - (int'(addr[1:0]) % sz);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      check("req_vld", dbus_req, 1);
      check("req_we", dbus_we, !ld);
      check("req_addr", dbus_addr, {addr[31:2], 2'b00});
      check("req_be", dbus_be, model_be(ea, sz));
      if (!ld) check("req_wdata", dbus_wdata, model_wdata(md, sz));
      check("req_stall", stall, 1);
      check("req_wb_we", wb_we, 0);
      if (i == k) begin
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
      end
    end
    @(negedge clk);
    dbus_ack = 1'b0;
    check("done_stall", stall, 0);
    check("done_req", dbus_req, 0);
    check("done_fault", mem_fault, 0);
    check("done_wb_we", wb_we, ld && rd != 4'd0);
    if (ld) begin
      check("done_wb_addr", wb_rd_addr, rd);
      check("done_wb_data", wb_rd_data, model_load(rdata, ea, sz, op_signed(op)));
    end
    @(negedge clk);
    check("post_no_reissue", dbus_req, 0);
    check("post_wb_we", wb_we, 0);
  endtask

  initial begin
    mem_op_t rop;
    rst_n      = 1'b0;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'd0;
    mem_params = '0;
    repeat (2) @(negedge clk);
    check("rst_req", dbus_req, 0);
    check("rst_we", dbus_we, 0);
    check("rst_addr", dbus_addr, 0);
    check("rst_be", dbus_be, 0);
    check("rst_wdata", dbus_wdata, 0);
    check("rst_wb_addr", wb_rd_addr, 0);
    check("rst_wb_data", wb_rd_data, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;

    do_op(MEM_OP_NONE, 4'd3, 32'h1234_5678, 32'd0, 1, 32'd0);
    do_op(MEM_OP_NONE, 4'd0, 32'hCAFE_0001, 32'd0, 1, 32'd0);
    do_op(MEM_OP_LB, 4'd4, 32'h0000_1003, 32'd0, 1, 32'h80AA_BBCC);
    check("lb_const", wb_rd_data, 32'hFFFF_FF80);
    do_op(MEM_OP_LBU, 4'd4, 32'h0000_1003, 32'd0, 1, 32'h80AA_BBCC);
    check("lbu_const", wb_rd_data, 32'h0000_0080);
    do_op(MEM_OP_SH, 4'd5, 32'h0000_2002, 32'hDEAD_BEEF, 3, 32'd0);
    do_op(MEM_OP_LW, 4'd6, 32'h0000_0010, 32'd0, 1, 32'h1111_2222);
    do_op(MEM_OP_LW, 4'd7, 32'h0000_0014, 32'd0, 2, 32'h3333_4444);
    check("lw_const", wb_rd_data, 32'h3333_4444);
    do_op(MEM_OP_LW, 4'd8, 32'h0000_0002, 32'd0, 1, 32'h5555_6666);

    // Reset in the middle of a bus access, followed by a stray ack.
    mem_params.mem_op  = MEM_OP_LW;
    mem_params.rd_addr = 4'd9;
    mem_params.rd_data = 32'h0000_0040;
    @(negedge clk);
    check("mid_req", dbus_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req", dbus_req, 0);
    check("mid_rst_wb_we", wb_we, 0);
    rst_n              = 1'b1;
    mem_params.mem_op  = MEM_OP_NONE;
    mem_params.rd_addr = 4'd0;
    dbus_ack           = 1'b1;
    dbus_rdata         = 32'hFFFF_FFFF;
    #1;
    check("mid_idle_stall", stall, 0);
    @(negedge clk);
    dbus_ack = 1'b0;
    check("stray_ack_req", dbus_req, 0);
    check("stray_ack_wb_we", wb_we, 0);

    for (int n = 0; n < 300; n++) begin
      rop = mem_op_t'($urandom_range(0, 8));
      do_op(rop, 4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(1, 4), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

MINAv2 memory stage. Consumes the `mem_params_t` bundle held by the EX/MEM register and performs loads and stores over a single-master req/ack data bus. It stalls the front of the pipeline while a bus access is outstanding and produces registered writeback signals for the MEM/WB register.

## Interface
- No parameters. All widths are fixed by the `types` package: 32-bit data and address, 4-bit register address.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mem_params`  in  `mem_params_t`  fields used by this block:
  - `rd_addr`: destination register.
  - `rd_data`: ALU result for non-memory ops, or effective address for memory ops.
  - `mem_op`: operation to perform.
  - `mem_data`: store data.
- `stall`  out  1  freezes EX/MEM and all upstream stages. Combinational from state and `mem_op`.
- `dbus_req`  out  1  bus request. Registered.
- `dbus_we`  out  1  1 = store, 0 = load. Registered.
- `dbus_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`. Registered.
- `dbus_be`  out  4  byte enables, little-endian lanes. Registered.
- `dbus_wdata`  out  32  store data replicated across lanes. Registered.
- `dbus_ack`  in  1  bus completion, one-cycle pulse.
- `dbus_rdata`  in  32  load data, valid together with `dbus_ack`.
- `wb_rd_addr`  out  4  writeback destination. Registered.
- `wb_rd_data`  out  32  writeback value. Registered.
- `wb_we`  out  1  writeback enable. Registered.
- `mem_fault`  out  1  misalignment fault pulse. Registered. Tied to 0 when the alignment check is compiled out.

## Operation
- `mem_op` values:
  - `MEM_OP_NONE`
  - Loads: `LB`, `LBU`, `LH`, `LHU`, `LW`
  - Stores: `SB`, `SH`, `SW`
- State machine: IDLE, REQ, DONE.
- **IDLE, `mem_op`=NONE**
  - Next edge: `wb_rd_addr` <= `rd_addr`, `wb_rd_data` <= `rd_data`, `wb_we` <= (`rd_addr` != 0). r0 is never written.
  - `stall`=0. State stays IDLE.
- **IDLE, load or store**
  - `stall`=1 combinationally.
  - Next edge: drive the bus outputs, set `wb_we` <= 0, go to REQ.
- **REQ**
  - `stall`=1. All `dbus_*` outputs held stable until `dbus_ack`.
  - On the `dbus_ack` edge:
    - Drop `dbus_req`.
    - For loads, `wb_rd_data` <= extracted value, `wb_rd_addr` <= `rd_addr`, `wb_we` <= (`rd_addr` != 0).
    - For stores, `wb_we` <= 0.
    - Go to DONE.
- **DONE**
  - `stall`=0, so EX/MEM advances at the end of this cycle.
  - The input still shows the completed op and must not be re-issued.
  - Next edge: unconditionally return to IDLE with `wb_we` <= 0.
- **Byte enables** (a = `rd_data[1:0]`):
  - Byte: `4'b0001 << a`
  - Half: `4'b0011 << {a[1],1'b0}`
  - Word: `4'b1111`
- **Store data replication**:
  - SB: `{4{mem_data[7:0]}}`
  - SH: `{2{mem_data[15:0]}}`
  - SW: `mem_data`
- **Load extraction**:
  - Shift `dbus_rdata` right by 8·a for bytes, or by 16·a[1] for halves.
  - LB/LH sign-extend to 32 bits. LBU/LHU zero-extend.
- `dbus_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `dbus_req`=0, `dbus_we`=0, `dbus_addr`=0, `dbus_be`=0, `dbus_wdata`=0; `wb_rd_addr`=0, `wb_rd_data`=0, `wb_we`=0; `mem_fault`=0. `stall` follows from IDLE and the input.
- Non-memory op: writeback is visible 1 cycle after the op is presented. Throughput is 1 op per cycle.
- Memory op with ack on cycle k of REQ (k≥1): the op occupies the stage for k+2 cycles.
  - Zero-wait-state case (ack in the first REQ cycle): issue cycle T, REQ at T+1, DONE at T+2.
  - Load writeback is visible in the DONE cycle.
- Reset asserted mid-REQ: at the next edge `dbus_req`=0, state IDLE, no writeback. A late `dbus_ack` is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned half access (a[0]=1) or word access (a≠0) in IDLE issues no bus request.
  - Next edge: `mem_fault` <= 1 for one cycle, `wb_we` <= 0, go to DONE.
  - `stall`=1 during the issue cycle only.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Low address bits are forced aligned: a[0] is ignored for halves, a is ignored for words.
  - `mem_fault` is constant 0.

## Test plan
- ALU op: `rd_addr`=3, `rd_data`=0x1234_5678, NONE → next cycle `wb_we`=1, `wb_rd_data`=0x1234_5678. A second op with `rd_addr`=0 → `wb_we`=0.
- LB at 0x1003, ack in first REQ cycle with `rdata`=0x80AA_BBCC → `dbus_addr`=0x1000, `be`=0b1000, `stall` high for 2 cycles. In DONE: `wb_rd_data`=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at 0x2002, `mem_data`=0xDEAD_BEEF, ack after 3 REQ cycles → `be`=0b1100, `wdata`=0xBEEF_BEEF, `we`=1. Bus outputs stay stable for 3 cycles, `wb_we`=0 throughout, no re-issue in DONE.
- Back-to-back LW 0x10 then LW 0x14 → two distinct requests, with exactly one IDLE cycle between DONE and the second issue.
- Reset asserted during REQ, then a stray ack → `dbus_req`=0 the next cycle, no writeback, state IDLE.
- With `MEM_ALIGN_CHECK_EN`: LW at 0x0002 → no `dbus_req`, `mem_fault`=1 for one cycle. Without the macro: `dbus_addr`=0x0000, `be`=0b1111.
